assoc_cache: RTL and testbench
==============================

# assoc_cache

Parametrised, fully associative, write-back/write-allocate cache that sits between the switch/key front end and the single-port backing RAM (1-cycle read latency). Single-word lines, true-LRU replacement via per-line age counters, saturating hit/miss counters for the HEX displays. It generalises the 32x8 memory block to arbitrary address/data width and line count, and adds the tag lookup, replacement and dirty write-back that the bare memory block lacks.

## Interface
- ADDR_W, 5, address width (tag = full address)
- DATA_W, 8, data width
- LINES, 4, number of cache lines (power of 2, >= 2)
- CNT_W, 8, width of hit/miss counters
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- req  in  1  request strobe, sampled only when ready=1
- wren  in  1  1 = write, 0 = read (sampled with req)
- address  in  ADDR_W  request address
- data  in  DATA_W  write data
- ready  out  1  controller idle, can accept req
- done  out  1  one-cycle pulse: request complete
- hit  out  1  valid with done: 1 = hit, 0 = miss
- q  out  DATA_W  read data (or written data on writes), held until next done
- hit_count, miss_count  out  CNT_W  saturating counters
- mem_address  out  ADDR_W  backing RAM address
- mem_data  out  DATA_W  backing RAM write data
- mem_wren  out  1  backing RAM write enable
- mem_q  in  DATA_W  backing RAM read data, valid the cycle after mem_address is sampled

## Operation
- Per line: valid, dirty, tag[ADDR_W], word[DATA_W], age[clog2(LINES)].
- Reset: valid=dirty=0, age[i]=i, state IDLE; ready=1, done=0, hit=0, q=0, counters=0, mem_wren=0, mem_address=0, mem_data=0. Backing RAM contents are not affected.
- IDLE: ready=1. On req=1, capture address/data/wren and go to LOOKUP. req while ready=0 is ignored (no queueing).
- LOOKUP: compare captured address against all valid tags.
  - Hit, line k: read sets q=word[k]; write sets word[k]=data, dirty[k]=1, q=data. Update LRU, increment hit_count, pulse done with hit=1, go to IDLE.
  - Miss: victim = lowest-index invalid line, otherwise the line with age=LINES-1. Go to WRITEBACK if victim is valid and dirty, otherwise FETCH. Increment miss_count.
- WRITEBACK (1 cycle): mem_address=victim tag, mem_data=victim word, mem_wren=1. Then FETCH.
- FETCH (1 cycle): mem_address=captured address, mem_wren=0. Then FILL.
- FILL: install line with tag=address, valid=1. A read takes word=mem_q, dirty=0, q=mem_q. A write takes word=data, dirty=1, q=data (the fetched word is discarded). Update LRU, pulse done with hit=0, go to IDLE.
- LRU update on access to line k: every line with age < age[k] increments; age[k]=0. Ages always remain a permutation of 0..LINES-1.
- Counters saturate at 2^CNT_W-1 and never wrap.
- mem_wren is 1 only in WRITEBACK. In IDLE and LOOKUP, mem_address and mem_data hold their last values.

## Timing
- The request is accepted at the edge ending cycle N (req=1, ready=1). ready is 0 from cycle N+1 until done.
- Hit: LOOKUP in N+1; done/hit/q valid in N+2; ready=1 in N+2.
- Clean miss: LOOKUP N+1, FETCH N+2, FILL N+3 (captures mem_q at end of N+3); done in N+4.
- Dirty miss: LOOKUP N+1, WRITEBACK N+2, FETCH N+3, FILL N+4; done in N+5.
- A new req may be presented in the done cycle (ready=1) and is accepted at that edge.
- resetn low at any point returns all state and outputs to reset values immediately, including mid-WRITEBACK (mem_wren drops asynchronously). The in-flight request is lost.

## Test plan
Defaults: ADDR_W=5, DATA_W=8, LINES=4; RAM preloaded with mem[a]=8'h40+a.
- After reset, read 3 -> miss, done at N+4, q=8'h43, hit=0, miss_count=1. Read 3 again -> done at N+2, hit=1, q=8'h43, hit_count=1.
- Write 3 with 8'hA5 -> hit, no mem_wren pulse, q=8'hA5. Read 3 -> q=8'hA5. mem[3] still 8'h43.
- Read 0, 1, 2 (fill), then read 4 -> victim is the line holding 3 (dirty). A single mem_wren pulse with mem_address=3, mem_data=8'hA5; done at N+5; q=8'h44. Afterwards mem[3]=8'hA5.
- Read 5 -> victim is the line holding 0 (clean); no mem_wren; done at N+4; q=8'h45. Read 0 -> miss, q=8'h40.
- Hold req=1 continuously with address 1 -> one request per done, each accepted only when ready=1. Assert resetn low during FETCH -> ready=1, counters=0, mem_wren=0. Read 3 -> miss, q=8'hA5.
- CNT_W=2: read 7 (miss), then five reads of 7 -> hit_count stays at 3, miss_count=1.

Source files
------------

// File: rtl/assoc_cache_if.sv
// assoc_cache_if: request/response bus between the front end and the cache,
// plus the cache's port to the single-port backing RAM.
interface assoc_cache_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req;
  logic              wren;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              done;
  logic              hit;
  logic [DATA_W-1:0] q;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  // The front end together with the backing RAM.
  modport master (
    output req, wren, address, data, mem_q,
    input  ready, done, hit, q, mem_address, mem_data, mem_wren
  );

  // The cache controller.
  modport slave (
    input  req, wren, address, data, mem_q,
    output ready, done, hit, q, mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/assoc_cache.sv
// assoc_cache: fully associative, write-back / write-allocate cache with
// single-word lines, true-LRU age counters and saturating hit/miss counters.
module assoc_cache #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int LINES  = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clock,
  input  logic             resetn,
  assoc_cache_if.slave     bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int AGE_W = $clog2(LINES);

  typedef logic [AGE_W-1:0] idx_t;
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FETCH, FILL} state_t;

  state_t            state;
  state_t            state_next;

  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [ADDR_W-1:0] tags  [LINES];
  logic [DATA_W-1:0] words [LINES];
  idx_t              ages  [LINES];

  logic [ADDR_W-1:0] cap_address;
  logic [DATA_W-1:0] cap_data;
  logic              cap_wren;
  idx_t              victim;

  logic              hit_found;
  idx_t              hit_idx;
  idx_t              victim_sel;
  logic              victim_dirty;
  logic              touch_en;
  idx_t              touch_idx;

  logic              done_r;
  logic              hit_r;
  logic [DATA_W-1:0] q_r;
  logic [ADDR_W-1:0] mem_address_r;
  logic [DATA_W-1:0] mem_data_r;
  logic              mem_wren_r;

  assign bus.ready       = (state == IDLE);
  assign bus.done        = done_r;
  assign bus.hit         = hit_r;
  assign bus.q           = q_r;
  assign bus.mem_address = mem_address_r;
  assign bus.mem_data    = mem_data_r;
  assign bus.mem_wren    = mem_wren_r;

  // Tag match against every valid line; the captured address is the full tag.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    for (int i = 0; i < LINES; i++) begin
      if (!hit_found && valid[i] && (tags[i] == cap_address)) begin
        hit_found = 1'b1;
        hit_idx   = idx_t'(i);
      end
    end
  end

  // Victim choice: lowest-index invalid line first, else the oldest line.
  always_comb begin
    logic inv_found;
    inv_found  = 1'b0;
    victim_sel = '0;
    for (int i = 0; i < LINES; i++) begin
      if (!inv_found && !valid[i]) begin
        inv_found  = 1'b1;
        victim_sel = idx_t'(i);
      end
    end
    if (!inv_found) begin
      for (int i = 0; i < LINES; i++) begin
        if (ages[i] == idx_t'(LINES - 1)) victim_sel = idx_t'(i);
      end
    end
    victim_dirty = valid[victim_sel] & dirty[victim_sel];
  end

  // A line is touched (made youngest) on a lookup hit or when it is filled.
  always_comb begin
    touch_en  = 1'b0;
    touch_idx = hit_idx;
    if (state == LOOKUP && hit_found) begin
      touch_en = 1'b1;
    end else if (state == FILL) begin
      touch_en  = 1'b1;
      touch_idx = victim;
    end
  end

  // Controller state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state decode: a hit returns straight to IDLE, a miss walks the refill path.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (bus.req) state_next = LOOKUP;
      LOOKUP: begin
        if (hit_found)         state_next = IDLE;
        else if (victim_dirty) state_next = WRITEBACK;
        else                   state_next = FETCH;
      end
      WRITEBACK: state_next = FETCH;
      FETCH:     state_next = FILL;
      FILL:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Line storage, request capture, responses, RAM port and LRU ages.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid         <= '0;
      dirty         <= '0;
      for (int i = 0; i < LINES; i++) begin
        tags[i]  <= '0;
        words[i] <= '0;
        ages[i]  <= idx_t'(i);
      end
      cap_address   <= '0;
      cap_data      <= '0;
      cap_wren      <= 1'b0;
      victim        <= '0;
      done_r        <= 1'b0;
      hit_r         <= 1'b0;
      q_r           <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      mem_address_r <= '0;
      mem_data_r    <= '0;
      mem_wren_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            cap_address <= bus.address;
            cap_data    <= bus.data;
            cap_wren    <= bus.wren;
          end
        end
        LOOKUP: begin
          if (hit_found) begin
            if (cap_wren) begin
              words[hit_idx] <= cap_data;
              dirty[hit_idx] <= 1'b1;
              q_r            <= cap_data;
            end else begin
              q_r <= words[hit_idx];
            end
            done_r <= 1'b1;
            hit_r  <= 1'b1;
            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
          end else begin
            victim <= victim_sel;
            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            if (victim_dirty) begin
              mem_address_r <= tags[victim_sel];
              mem_data_r    <= words[victim_sel];
              mem_wren_r    <= 1'b1;
            end else begin
              mem_address_r <= cap_address;
              mem_wren_r    <= 1'b0;
            end
          end
        end
        WRITEBACK: begin
          mem_address_r <= cap_address;
          mem_wren_r    <= 1'b0;
        end
        FETCH: begin
          mem_wren_r <= 1'b0;
        end
        FILL: begin
          tags[victim]  <= cap_address;
          valid[victim] <= 1'b1;
          if (cap_wren) begin
            words[victim] <= cap_data;
            dirty[victim] <= 1'b1;
            q_r           <= cap_data;
          end else begin
            words[victim] <= bus.mem_q;
            dirty[victim] <= 1'b0;
            q_r           <= bus.mem_q;
          end
          done_r <= 1'b1;
          hit_r  <= 1'b0;
        end
        default: begin
          mem_wren_r <= 1'b0;
        end
      endcase

      if (touch_en) begin
        for (int i = 0; i < LINES; i++) begin
          if (idx_t'(i) == touch_idx)        ages[i] <= '0;
          else if (ages[i] < ages[touch_idx]) ages[i] <= ages[i] + idx_t'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: directed and random requests against two cache instances
// (8-bit and 2-bit counters) sharing one stimulus, checked against a
// line-list / recency-queue reference model of the cache.
module tb_assoc_cache;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int LINES  = 4;

  logic       clock = 1'b0;
  logic       resetn;
  logic       preload;
  logic       req_s;
  logic       wren_s;
  logic [4:0] addr_s;
  logic [7:0] data_s;
  logic [7:0] hc0, mc0;
  logic [1:0] hc1, mc1;
  logic [7:0] ram0 [32];
  logic [7:0] ram1 [32];

  int total = 0;
  int bad   = 0;

  bit         m_valid [LINES];
  bit         m_dirty [LINES];
  logic [4:0] m_tag   [LINES];
  logic [7:0] m_word  [LINES];
  int         m_order [$];
  logic [7:0] m_mem   [32];
  int         m_hits;
  int         m_misses;

  assoc_cache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
  assoc_cache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  assign bus0.req     = req_s;
  assign bus0.wren    = wren_s;
  assign bus0.address = addr_s;
  assign bus0.data    = data_s;
  assign bus1.req     = req_s;
  assign bus1.wren    = wren_s;
  assign bus1.address = addr_s;
  assign bus1.data    = data_s;

  assoc_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES), .CNT_W(8)) dut0 (
    .clock(clock), .resetn(resetn), .bus(bus0), .hit_count(hc0), .miss_count(mc0)
  );

  assoc_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES), .CNT_W(2)) dut1 (
    .clock(clock), .resetn(resetn), .bus(bus1), .hit_count(hc1), .miss_count(mc1)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Backing RAMs: synchronous write, registered read, preloaded with 0x40+a.
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) begin
        ram0[i] <= 8'(8'h40 + i);
        ram1[i] <= 8'(8'h40 + i);
      end
    end else begin
      if (bus0.mem_wren) ram0[bus0.mem_address] <= bus0.mem_data;
      if (bus1.mem_wren) ram1[bus1.mem_address] <= bus1.mem_data;
    end
    bus0.mem_q <= ram0[bus0.mem_address];
    bus1.mem_q <= ram1[bus1.mem_address];
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] sat(input int n, input int limit);
    return (n > limit) ? limit : n;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
      m_word[i]  = '0;
    end
    m_order.delete();
    for (int i = 0; i < LINES; i++) m_order.push_back(i);
    m_hits   = 0;
    m_misses = 0;
  endtask

  // Most recently used line sits at the front of the queue.
  task automatic modelTouch(input int k);
    for (int i = 0; i < m_order.size(); i++) begin
      if (m_order[i] == k) begin
        m_order.delete(i);
        break;
      end
    end
    m_order.push_front(k);
  endtask

  task automatic modelAccess(input bit w, input logic [4:0] a, input logic [7:0] d,
                             output bit e_hit, output logic [7:0] e_q, output int e_lat,
                             output bit e_wb, output logic [4:0] e_wba, output logic [7:0] e_wbd);
    int k = -1;
    int v = -1;
    e_wb  = 1'b0;
    e_wba = '0;
    e_wbd = '0;
    for (int i = 0; i < LINES; i++) if (m_valid[i] && m_tag[i] == a) k = i;
    if (k >= 0) begin
      e_hit = 1'b1;
      if (w) begin
        m_word[k]  = d;
        m_dirty[k] = 1'b1;
      end
      e_q   = m_word[k];
      e_lat = 2;
      m_hits++;
      modelTouch(k);
    end else begin
      e_hit = 1'b0;
      m_misses++;
      for (int i = LINES - 1; i >= 0; i--) if (!m_valid[i]) v = i;
      if (v < 0) v = m_order[LINES-1];
      if (m_valid[v] && m_dirty[v]) begin
        e_wb  = 1'b1;
        e_wba = m_tag[v];
        e_wbd = m_word[v];
        m_mem[m_tag[v]] = m_word[v];
        e_lat = 5;
      end else begin
        e_lat = 4;
      end
      m_valid[v] = 1'b1;
      m_tag[v]   = a;
      if (w) begin
        m_word[v]  = d;
        m_dirty[v] = 1'b1;
      end else begin
        m_word[v]  = m_mem[a];
        m_dirty[v] = 1'b0;
      end
      e_q = m_word[v];
      modelTouch(v);
    end
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_hc0"}, hc0, sat(m_hits, 255));
    checkOutput({tag, "_mc0"}, mc0, sat(m_misses, 255));
    checkOutput({tag, "_hc1"}, hc1, sat(m_hits, 3));
    checkOutput({tag, "_mc1"}, mc1, sat(m_misses, 3));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, bus0.ready, 1);
    checkOutput({tag, "_done"}, bus0.done, 0);
    checkOutput({tag, "_hit"}, bus0.hit, 0);
    checkOutput({tag, "_q"}, bus0.q, 0);
    checkOutput({tag, "_mem_wren"}, bus0.mem_wren, 0);
    checkOutput({tag, "_mem_address"}, bus0.mem_address, 0);
    checkOutput({tag, "_mem_data"}, bus0.mem_data, 0);
    checkCounters(tag);
  endtask

  // One request presented at a falling edge; follows it to done.
  task automatic applyStimulus(input bit w, input logic [4:0] a, input logic [7:0] d);
    bit         e_hit, e_wb, got;
    logic [7:0] e_q, e_wbd, wb_d;
    logic [4:0] e_wba, wb_a;
    int         e_lat, k, wb_cnt;
    modelAccess(w, a, d, e_hit, e_q, e_lat, e_wb, e_wba, e_wbd);
    checkOutput("ready_before_req", bus0.ready, 1);
    req_s  = 1'b1;
    wren_s = w;
    addr_s = a;
    data_s = d;
    @(posedge clock);
    @(negedge clock);
    req_s  = 1'b0;
    k      = 1;
    wb_cnt = 0;
    wb_a   = '0;
    wb_d   = '0;
    got    = 1'b0;
    checkOutput("busy_after_accept", bus0.ready, 0);
    while (!got && k <= 20) begin
      if (bus0.mem_wren) begin
        wb_cnt++;
        wb_a = bus0.mem_address;
        wb_d = bus0.mem_data;
      end
      if (bus0.done) got = 1'b1;
      else begin
        @(negedge clock);
        k++;
      end
    end
    checkOutput("done_seen", got, 1);
    checkOutput("latency", k, e_lat);
    checkOutput("hit", bus0.hit, e_hit);
    checkOutput("q", bus0.q, e_q);
    checkOutput("q_dut1", bus1.q, e_q);
    checkOutput("ready_at_done", bus0.ready, 1);
    checkOutput("wb_pulses", wb_cnt, e_wb);
    if (e_wb) begin
      checkOutput("wb_address", wb_a, e_wba);
      checkOutput("wb_data", wb_d, e_wbd);
    end
    checkCounters("req");
  endtask

  // req held high on one read address: exactly one acceptance per done.
  task automatic heldRequests(input logic [4:0] a, input int n);
    bit         e_hit, e_wb;
    logic [7:0] e_q, e_wbd;
    logic [4:0] e_wba;
    int         e_lat;
    int         k = 0;
    int         dones = 0;
    int         cycles = 0;
    modelAccess(1'b0, a, 8'h00, e_hit, e_q, e_lat, e_wb, e_wba, e_wbd);
    req_s  = 1'b1;
    wren_s = 1'b0;
    addr_s = a;
    data_s = 8'h00;
    while (dones < n && cycles < 100) begin
      @(negedge clock);
      k++;
      cycles++;
      checkOutput("held_done", bus0.done, k == e_lat);
      checkOutput("held_ready", bus0.ready, k == e_lat);
      if (bus0.done) begin
        checkOutput("held_q", bus0.q, e_q);
        checkOutput("held_hit", bus0.hit, e_hit);
        dones++;
        if (dones == n) req_s = 1'b0;
        else begin
          modelAccess(1'b0, a, 8'h00, e_hit, e_q, e_lat, e_wb, e_wba, e_wbd);
          k = 0;
        end
      end
    end
    checkOutput("held_count", dones, n);
    checkCounters("held");
  endtask

  // Clean read miss interrupted by reset while the RAM read is in flight.
  task automatic resetDuringFetch(input logic [4:0] a);
    req_s  = 1'b1;
    wren_s = 1'b0;
    addr_s = a;
    @(posedge clock);
    @(negedge clock);
    req_s = 1'b0;
    @(negedge clock);
    checkOutput("fetch_address", bus0.mem_address, a);
    checkOutput("fetch_wren", bus0.mem_wren, 0);
    checkOutput("fetch_busy", bus0.ready, 0);
    resetn = 1'b0;
    #1;
    modelReset();
    checkResetValues("midreset");
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    resetn  = 1'b1;
    preload = 1'b1;
    req_s   = 1'b0;
    wren_s  = 1'b0;
    addr_s  = '0;
    data_s  = '0;
    for (int i = 0; i < 32; i++) m_mem[i] = 8'(8'h40 + i);
    modelReset();
    #1 resetn = 1'b0;
    @(negedge clock);
    @(negedge clock);
    preload = 1'b0;
    checkResetValues("reset");
    resetn = 1'b1;

    $display("[TB] directed: miss, hit, write hit");
    applyStimulus(1'b0, 5'd3, 8'h00);
    applyStimulus(1'b0, 5'd3, 8'h00);
    applyStimulus(1'b1, 5'd3, 8'hA5);
    applyStimulus(1'b0, 5'd3, 8'h00);
    checkOutput("ram3_untouched", ram0[3], 8'h43);

    $display("[TB] directed: fill and dirty eviction");
    applyStimulus(1'b0, 5'd0, 8'h00);
    applyStimulus(1'b0, 5'd1, 8'h00);
    applyStimulus(1'b0, 5'd2, 8'h00);
    applyStimulus(1'b0, 5'd4, 8'h00);
    checkOutput("ram3_written_back", ram0[3], 8'hA5);
    applyStimulus(1'b0, 5'd5, 8'h00);
    applyStimulus(1'b0, 5'd0, 8'h00);

    $display("[TB] directed: held request and reset during fetch");
    heldRequests(5'd1, 4);
    resetDuringFetch(5'd9);
    applyStimulus(1'b0, 5'd3, 8'h00);

    $display("[TB] directed: counter saturation");
    resetn = 1'b0;
    #1;
    modelReset();
    checkResetValues("reset2");
    @(negedge clock);
    resetn = 1'b1;
    applyStimulus(1'b0, 5'd7, 8'h00);
    repeat (5) applyStimulus(1'b0, 5'd7, 8'h00);

    $display("[TB] random requests");
    for (int n = 0; n < 80; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), 8'($urandom));
    end

    @(negedge clock);
    for (int i = 0; i < 32; i++) checkOutput("ram_final", ram0[i], m_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
